// File: rtl/attn_pkg.sv
// -----------------------------------------------------------------------------
// attn_pkg
// Shared constants and types for the attention result collector slice.
//   ANS_W_DEFAULT : default answer element width
//   DEPTH         : number of result entries held by the collector
//   ADDR_W        : element index width (0..DEPTH-1)
//   CNT_W         : captured-element counter width (0..DEPTH inclusive)
//   CHK_W         : checksum accumulator width (optional feature)
//   state_t       : collector FSM state encoding
// -----------------------------------------------------------------------------
package attn_pkg;

    localparam int unsigned ANS_W_DEFAULT = 18;
    localparam int unsigned DEPTH         = 64;
    localparam int unsigned ADDR_W        = 6;
    localparam int unsigned CNT_W         = 7;
    localparam int unsigned CHK_W         = 24;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        CAPTURE    = 2'd2,
        FULL       = 2'd3
    } state_t;

endpackage : attn_pkg

// File: rtl/attn_result_ram.sv
// -----------------------------------------------------------------------------
// attn_result_ram
// Simple dual-port result store: one synchronous write port, one registered
// read port. A read and a write to the same address on the same edge return
// the pre-write contents. Storage is not reset.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   rd_en    in   read enable (updates the read register)
//   raddr    in   read address
//   rdata    out  registered read data
// -----------------------------------------------------------------------------
module attn_result_ram #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : attn_result_ram

// File: rtl/attn_result_collector.sv
// -----------------------------------------------------------------------------
// attn_result_collector
// Collects the row-major answer stream of the attention engine into a 64-entry
// store and offers a registered random-access readout.
//
// Parameters:
//   TIMEOUT_LIMIT : max cycles from start to the first done before timeout
//   ANS_W         : answer element width
// Ports:
//   clk          in   clock, all state on rising edge
//   reset        in   asynchronous active-high reset
//   start        in   one-cycle pulse arming a new collection
//   done         in   answer-valid strobe
//   answer       in   answer element, valid with done
//   rd_req       in   readout request
//   rd_addr      in   readout element index
//   rd_valid     out  readout response valid (one cycle after rd_req)
//   rd_data      out  readout data (0 when the index is not yet captured)
//   busy         out  collection in progress (WAIT_FIRST or CAPTURE)
//   full         out  all 64 entries captured
//   timeout_err  out  sticky: no first done within TIMEOUT_LIMIT cycles
//   overrun_err  out  sticky: done received while full
//   count        out  number of captured elements, 0..64
//   checksum     out  (only with ATTN_COLLECT_CHECKSUM_EN) 24-bit running sum
//                     of accepted answers, cleared on accepted start
//
// Configuration macro: ATTN_COLLECT_CHECKSUM_EN
// -----------------------------------------------------------------------------
module attn_result_collector
    import attn_pkg::*;
#(
    parameter int unsigned TIMEOUT_LIMIT = 250,
    parameter int unsigned ANS_W         = ANS_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              done,
    input  logic [ANS_W-1:0]  answer,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [ANS_W-1:0]  rd_data,
    output logic              busy,
    output logic              full,
    output logic              timeout_err,
    output logic              overrun_err,
    output logic [CNT_W-1:0]  count
`ifdef ATTN_COLLECT_CHECKSUM_EN
    ,
    output logic [CHK_W-1:0]  checksum
`endif
);

    localparam int unsigned LAT_W = $clog2(TIMEOUT_LIMIT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               terr_q, terr_d;
    logic               oerr_q, oerr_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               start_ok;
    logic               wr_en;

    logic               rd_valid_q;
    logic               rd_hit_q;
    logic [ANS_W-1:0]   ram_rdata;

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        full_d   = full_q;
        terr_d   = terr_q;
        oerr_d   = oerr_q;
        lat_d    = lat_q;
        wr_en    = 1'b0;
        start_ok = 1'b0;

        case (state_q)
            IDLE, FULL: begin
                if (start) begin
                    start_ok = 1'b1;
                    count_d  = '0;
                    full_d   = 1'b0;
                    terr_d   = 1'b0;
                    oerr_d   = 1'b0;
                    lat_d    = '0;
                    state_d  = WAIT_FIRST;
                end else if (state_q == FULL && done) begin
                    // Data discarded; only the sticky flag records it.
                    oerr_d = 1'b1;
                end
            end

            WAIT_FIRST: begin
                if (done) begin
                    wr_en   = 1'b1;
                    count_d = CNT_W'(1);
                    state_d = CAPTURE;
                end else if (lat_q == LAT_W'(TIMEOUT_LIMIT - 1)) begin
                    // This idle cycle brings the latency count to the limit.
                    terr_d  = 1'b1;
                    lat_d   = '0;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            CAPTURE: begin
                if (done) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(DEPTH - 1)) begin
                        full_d  = 1'b1;
                        state_d = FULL;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            full_q  <= 1'b0;
            terr_q  <= 1'b0;
            oerr_q  <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            terr_q  <= terr_d;
            oerr_q  <= oerr_d;
            lat_q   <= lat_d;
        end
    end

    // ------------------------------------------------------------------
    // Readout: the hit flag is decided against the count at request time,
    // so a same-edge write of the requested entry still reads as 0 and
    // stale entries after a reset are never exposed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            rd_hit_q   <= rd_req && ({1'b0, rd_addr} < count_q);
        end
    end

    attn_result_ram #(
        .DATA_W (ANS_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count_q[ADDR_W-1:0]),
        .wdata (answer),
        .rd_en (rd_req),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

`ifdef ATTN_COLLECT_CHECKSUM_EN
    logic [CHK_W-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (start_ok) begin
            chk_d = '0;
        end else if (wr_en) begin
            chk_d = chk_q + CHK_W'(answer);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign checksum = chk_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_hit_q ? ram_rdata : '0;
    assign busy        = (state_q == WAIT_FIRST) || (state_q == CAPTURE);
    assign full        = full_q;
    assign timeout_err = terr_q;
    assign overrun_err = oerr_q;
    assign count       = count_q;

endmodule : attn_result_collector

// File: tb/tb_attn_result_collector.sv
// -----------------------------------------------------------------------------
// tb_attn_result_collector
// Directed self-checking bench for attn_result_collector. Readout expectations
// come from a bench-side memory model and are queued at request time, then
// popped when the response appears.
// Optional: define ATTN_COLLECT_CHECKSUM_EN to exercise the checksum output.
// -----------------------------------------------------------------------------
module tb_attn_result_collector;

    localparam int unsigned AW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          done;
    logic [AW-1:0] answer;
    logic          rd_req;
    logic [5:0]    rd_addr;
    logic          rd_valid;
    logic [AW-1:0] rd_data;
    logic          busy;
    logic          full;
    logic          timeout_err;
    logic          overrun_err;
    logic [6:0]    count;
`ifdef ATTN_COLLECT_CHECKSUM_EN
    logic [23:0]   checksum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] model_mem [64];
    int            model_count = 0;
    logic [AW-1:0] exp_q [$];

    attn_result_collector #(
        .TIMEOUT_LIMIT (250),
        .ANS_W         (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .answer      (answer),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .full        (full),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .count       (count)
`ifdef ATTN_COLLECT_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] model_read(input int a);
        return (a < model_count) ? model_mem[a] : '0;
    endfunction

    task automatic model_write(input logic [AW-1:0] v);
        if (model_count < 64) begin
            model_mem[model_count] = v;
            model_count++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_count = 0;
    endtask

    task automatic write_one(input logic [AW-1:0] v);
        done   = 1'b1;
        answer = v;
        tick();
        done   = 1'b0;
        model_write(v);
    endtask

    task automatic collect(input string tag);
        logic [AW-1:0] e;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, 32'(rd_data), 32'(e));
        end else begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
    endtask

    task automatic read_req(input string tag, input int a);
        rd_req  = 1'b1;
        rd_addr = 6'(a);
        exp_q.push_back(model_read(a));
        tick();
        rd_req  = 1'b0;
        collect(tag);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        done    = 1'b0;
        answer  = '0;
        rd_req  = 1'b0;
        rd_addr = '0;

        // Reset state
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_oerr", 32'(overrun_err), 32'd0);
        check("rst_rdvalid", 32'(rd_valid), 32'd0);
        check("rst_rddata", 32'(rd_data), 32'd0);
`ifdef ATTN_COLLECT_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Full capture: first done 20 cycles after start, 64 back-to-back
        pulse_start();
        check("wf_busy", 32'(busy), 32'd1);
        check("wf_count", 32'(count), 32'd0);
        repeat (19) tick();
        check("wf_busy_19", 32'(busy), 32'd1);
        for (int i = 0; i < 63; i++) write_one(AW'(i * 3));
        check("cap63_count", 32'(count), 32'd63);
        check("cap63_full", 32'(full), 32'd0);
        check("cap63_busy", 32'(busy), 32'd1);
        write_one(AW'(63 * 3));
        check("cap64_count", 32'(count), 32'd64);
        check("cap64_full", 32'(full), 32'd1);
        check("cap64_busy", 32'(busy), 32'd0);
        read_req("rd10", 10);
        tick();
        check("rdvalid_idle", 32'(rd_valid), 32'd0);
        read_req("rd0", 0);
        read_req("rd63", 63);

        // Overrun while full
        write_one(AW'(5));
        check("ovr_flag", 32'(overrun_err), 32'd1);
        check("ovr_count", 32'(count), 32'd64);
        read_req("ovr_rd63", 63);

        // Timeout: 249 idle cycles still waiting, 250th times out
        pulse_start();
        check("rs_oerr_clr", 32'(overrun_err), 32'd0);
        check("rs_full_clr", 32'(full), 32'd0);
        check("rs_count_clr", 32'(count), 32'd0);
        repeat (249) tick();
        check("to249_busy", 32'(busy), 32'd1);
        check("to249_terr", 32'(timeout_err), 32'd0);
        tick();
        check("to_terr", 32'(timeout_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_count", 32'(count), 32'd0);
        read_req("to_rd10", 10);
        pulse_start();
        check("to_clr", 32'(timeout_err), 32'd0);
        check("to_restart_busy", 32'(busy), 32'd1);

        // Capture with a long gap and an ignored start
        for (int i = 0; i < 3; i++) write_one(AW'(i + 1000));
        repeat (300) tick();
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_terr", 32'(timeout_err), 32'd0);
        check("gap_count", 32'(count), 32'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_start_count", 32'(count), 32'd3);
        check("ign_start_busy", 32'(busy), 32'd1);
        for (int i = 3; i < 7; i++) write_one(AW'(i + 1000));

        // Same-edge write and read of entry 7
        done    = 1'b1;
        answer  = 18'h3FFFF;
        rd_req  = 1'b1;
        rd_addr = 6'd7;
        exp_q.push_back(model_read(7));
        tick();
        done    = 1'b0;
        rd_req  = 1'b0;
        model_write(18'h3FFFF);
        collect("rw7_old");
        check("rw7_count", 32'(count), 32'd8);
        read_req("rw7_new", 7);
        read_req("rd6", 6);

        // 40 writes then a reset pulse
        for (int i = 8; i < 40; i++) write_one(AW'(i * 7));
        check("w40_count", 32'(count), 32'd40);
        read_req("rd39", 39);
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        tick();
        check("arst_count", 32'(count), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        reset = 1'b0;
        model_count = 0;
        read_req("arst_rd0", 0);

`ifdef ATTN_COLLECT_CHECKSUM_EN
        pulse_start();
        check("chk_clr", 32'(checksum), 32'd0);
        for (int i = 0; i < 64; i++) write_one(18'h3FFFF);
        check("chk_full", 32'(full), 32'd1);
        check("chk_sum", 32'(checksum), 32'hFFFFC0);
        write_one(18'h1);
        check("chk_ovr_sum", 32'(checksum), 32'hFFFFC0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_attn_result_collector

// File: doc/attn_result_collector.md
ATTN_RESULT_COLLECTOR -- requirements
Module: attn_result_collector

Interface
REQ-001 Parameter: TIMEOUT_LIMIT, 250, max cycles from start to first done before timeout.
REQ-002 Parameter: ANS_W, 18, answer element width.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle pulse, coincident with the engine's en rise; arms collection.
REQ-006 Port: done  input  1  answer-valid strobe from the attention engine.
REQ-007 Port: answer  input  ANS_W  result element, row-major, valid when done=1.
REQ-008 Port: rd_req / rd_addr  input  1 / 6  readout request and element index 0..63.
REQ-009 Port: rd_valid / rd_data  output  1 / ANS_W  readout response.
REQ-010 Port: busy, full, timeout_err, overrun_err  output  1 each  status flags.
REQ-011 Port: count  output  7  number of elements captured, 0..64.

Function
REQ-012 FSM states IDLE, WAIT_FIRST, CAPTURE, FULL; reset state IDLE.
REQ-013 IDLE/FULL + start: count:=0, full:=0, both error flags cleared, latency counter:=0, go WAIT_FIRST.
REQ-014 WAIT_FIRST: latency counter increments each cycle without done; done -> write answer to entry 0, count:=1, go CAPTURE.
REQ-015 WAIT_FIRST: counter reaching TIMEOUT_LIMIT with done=0 -> timeout_err:=1 (sticky), go IDLE.
REQ-016 CAPTURE: each done cycle writes answer at entry count, count+1; gaps (done=0) allowed, no timeout in CAPTURE.
REQ-017 The 64th write sets full:=1 and enters FULL in the same edge; count saturates at 64.
REQ-018 FULL: done=1 -> overrun_err:=1 (sticky), data discarded, count unchanged.
REQ-019 start in WAIT_FIRST or CAPTURE is ignored.
REQ-020 busy=1 exactly in WAIT_FIRST and CAPTURE.
REQ-021 Readout: rd_req at edge N -> rd_valid=1, rd_data=mem[rd_addr] at edge N+1; rd_valid=0 otherwise; legal in every state.
REQ-022 rd_addr >= count -> rd_data=0, rd_valid still 1.
REQ-023 Same-cycle write and read of one address returns the old (pre-write) data.
REQ-024 answer stored unmodified, full ANS_W bits.

Reset
REQ-025 reset asserted: state IDLE; count, full, busy, timeout_err, overrun_err, rd_valid, rd_data, latency counter all 0.
REQ-026 reset mid-capture aborts immediately; memory contents undefined-but-unread (REQ-022 masks them).

Configuration
REQ-027 Macro ATTN_COLLECT_CHECKSUM_EN defined: extra output checksum (24 bits), reset 0, cleared on accepted start, += zero-extended answer on every accepted write (modulo 2^24).
REQ-028 Macro undefined: no checksum port, no accumulator logic.

Structure
REQ-029 Package attn_pkg holds ANS_W default, DEPTH=64, ADDR_W=6, FSM state typedef.
REQ-030 One sub-module attn_result_ram: 64 x ANS_W, one write port, one registered read port.

Verification
REQ-031 start, first done 20 cycles later, 64 consecutive done with answer=i*3 -> count=64, full=1, busy=0, rd_addr=10 gives 30 one cycle later.
REQ-032 start, no done for 250 cycles -> timeout_err=1, state IDLE, count=0; next start clears it.
REQ-033 After full, one extra done with answer=5 -> overrun_err=1, rd_addr=63 unchanged.
REQ-034 40 writes then reset pulse -> count=0, full=0, rd_addr=0 returns 0.
REQ-035 Write entry 7 (value 0x3FFFF) while reading addr 7 same cycle -> returns 0 (count was 7); next read returns 0x3FFFF.
REQ-036 With ATTN_COLLECT_CHECKSUM_EN, 64 answers of 0x3FFFF -> checksum=0xFFFFC0.
